sobel_gradient_gen: RTL and testbench

SOBEL_GRADIENT_GEN -- requirements
Module: sobel_gradient_gen

---
 rtl/sobel_gradient_gen_if.sv | 22 ++
 rtl/sobel_gradient_gen.sv | 100 ++++++++++
 tb/tb_sobel_gradient_gen.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_gradient_gen_if.sv
// Column-stream and gradient-output handshake bundle for sobel_gradient_gen.
// master drives columns and grad_ready; slave is the gradient generator.
interface sobel_gradient_gen_if;
    logic               col_valid;
    logic [23:0]        col_in;
    logic               row_start;
    logic               col_ready;
    logic               grad_ready;
    logic signed [10:0] gx;
    logic signed [10:0] gy;
    logic               start_t_grad;

    modport master (
        output col_valid, col_in, row_start, grad_ready,
        input  col_ready, gx, gy, start_t_grad
    );

    modport slave (
        input  col_valid, col_in, row_start, grad_ready,
        output col_ready, gx, gy, start_t_grad
    );
endinterface

// File: rtl/sobel_gradient_gen.sv
// 3x3 Sobel |gx|/|gy| from a stream of 3-pixel columns; result registered one cycle after the window completes.
// Backpressure: the output register holds while grad_ready is low, and col_ready drops so no column is lost.
module sobel_gradient_gen #(
    parameter int IMG_WIDTH = 640
) (
    input  logic                 clk,
    input  logic                 n_rst,
    sobel_gradient_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FILL1, FILL2, RUN} state_t;

    localparam logic [10:0] LP_WIDTH = 11'(IMG_WIDTH);

    state_t      r_state;
    logic [10:0] r_cnt;
    logic [23:0] r_c0, r_c1, r_c2;
    logic        r_pend;
    logic        r_vld;
    logic [10:0] r_gx, r_gy;

    logic        w_accept;
    logic        w_out_free;
    logic        w_win_done;
    logic [10:0] w_cnt_nxt;
    logic [10:0] w_gx, w_gy;

    // Weighted 1-2-1 sum; max 4*255 = 1020, fits in 11 bits unsigned.
    function automatic logic [10:0] wsum(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
    endfunction

    function automatic logic [10:0] absdiff(input logic [10:0] x, input logic [10:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

    assign w_out_free = !r_vld || bus.grad_ready;
    assign w_accept   = bus.col_valid && bus.col_ready;
    assign w_cnt_nxt  = r_cnt + 11'd1;
    assign w_win_done = w_accept && !bus.row_start && (r_state == FILL2 || r_state == RUN);

    assign w_gx = absdiff(wsum(r_c2[23:16], r_c2[15:8], r_c2[7:0]),
                          wsum(r_c0[23:16], r_c0[15:8], r_c0[7:0]));
    assign w_gy = absdiff(wsum(r_c0[23:16], r_c1[23:16], r_c2[23:16]),
                          wsum(r_c0[7:0],   r_c1[7:0],   r_c2[7:0]));

    assign bus.col_ready    = !(r_vld && !bus.grad_ready);
    assign bus.start_t_grad = r_vld;
    assign bus.gx           = r_gx;
    assign bus.gy           = r_gy;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_c0    <= '0;
            r_c1    <= '0;
            r_c2    <= '0;
            r_pend  <= 1'b0;
            r_vld   <= 1'b0;
            r_gx    <= '0;
            r_gy    <= '0;
        end else begin
            if (w_accept) begin
                r_c0 <= r_c1;
                r_c1 <= r_c2;
                r_c2 <= bus.col_in;
                if (bus.row_start) begin
                    r_state <= FILL1;
                    r_cnt   <= 11'd1;
                end else begin
                    case (r_state)
                        IDLE: ;
                        default: begin
                            r_cnt <= w_cnt_nxt;
                            if (w_cnt_nxt == LP_WIDTH)
                                r_state <= IDLE;
                            else if (r_state == FILL1)
                                r_state <= FILL2;
                            else
                                r_state <= RUN;
                        end
                    endcase
                end
            end

            // A completed window waits here one cycle; the window regs cannot shift
            // underneath it because col_ready is low whenever the output is stalled.
            if (w_win_done)
                r_pend <= 1'b1;
            else if (w_out_free)
                r_pend <= 1'b0;

            if (w_out_free) begin
                r_vld <= r_pend;
                r_gx  <= r_pend ? w_gx : '0;
                r_gy  <= r_pend ? w_gy : '0;
            end
        end
    end
endmodule

// File: tb/tb_sobel_gradient_gen.sv
// Directed-vector bench for sobel_gradient_gen with IMG_WIDTH = 8.
module tb_sobel_gradient_gen;
    localparam int W = 8;

    logic clk = 1'b0;
    logic n_rst;
    sobel_gradient_gen_if bus();

    sobel_gradient_gen #(.IMG_WIDTH(W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n_out  = 0;
    int q_gx[$];
    int q_gy[$];

    // Record every output consumed at the coming rising edge.
    always begin
        @(negedge clk);
        #3;
        if (bus.start_t_grad === 1'b1 && bus.grad_ready === 1'b1) begin
            n_out++;
            q_gx.push_back(int'(bus.gx));
            q_gy.push_back(int'(bus.gy));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [23:0] d, input logic rs);
        int guard;
        guard = 0;
        bus.col_valid = 1'b1;
        bus.col_in    = d;
        bus.row_start = rs;
        #1;
        while (bus.col_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (bus.col_ready !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL push_timeout: col_ready=%b expected 1 within 50 cycles", bus.col_ready);
        end
        @(negedge clk);
        #1;
        bus.col_valid = 1'b0;
        bus.row_start = 1'b0;
    endtask

    task automatic test_reset;
        int base;
        n_chk++; if (bus.start_t_grad !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b expected 0", bus.start_t_grad); end
        n_chk++; if (bus.gx !== 11'd0) begin n_fail++; $display("FAIL rst_gx: got %0d expected 0", bus.gx); end
        n_chk++; if (bus.gy !== 11'd0) begin n_fail++; $display("FAIL rst_gy: got %0d expected 0", bus.gy); end
        n_chk++; if (bus.col_ready !== 1'b1) begin n_fail++; $display("FAIL rst_col_ready: got %b expected 1", bus.col_ready); end
        @(negedge clk);
        #1;
        n_rst = 1'b1;
        bus.grad_ready = 1'b1;
        #1;
        n_chk++; if (bus.col_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_col_ready: got %b expected 1", bus.col_ready); end
        base = n_out;
        push(24'hFFFFFF, 1'b0);
        push(24'h000000, 1'b0);
        push(24'hFFFFFF, 1'b0);
        push(24'h000000, 1'b0);
        idle(3);
        n_chk++; if (n_out - base != 0) begin n_fail++; $display("FAIL idle_discard_outputs: got %0d expected 0", n_out - base); end
    endtask

    task automatic test_flat_row;
        int base;
        bus.grad_ready = 1'b1;
        q_gx.delete();
        q_gy.delete();
        base = n_out;
        push(24'h646464, 1'b1);
        for (int i = 1; i < W; i++) push(24'h646464, 1'b0);
        idle(3);
        n_chk++; if (n_out - base != W - 2) begin n_fail++; $display("FAIL flat_count: got %0d expected %0d", n_out - base, W - 2); end
        foreach (q_gx[i]) begin
            n_chk++; if (q_gx[i] != 0 || q_gy[i] != 0) begin n_fail++; $display("FAIL flat_value[%0d]: got gx=%0d gy=%0d expected 0 0", i, q_gx[i], q_gy[i]); end
        end
    endtask

    task automatic test_grad_x;
        bus.grad_ready = 1'b1;
        push(24'h000000, 1'b1);
        push(24'h000000, 1'b0);
        push(24'hFFFFFF, 1'b0);
        n_chk++; if (bus.start_t_grad !== 1'b0) begin n_fail++; $display("FAIL gx_latency_early: got %b expected 0", bus.start_t_grad); end
        idle(1);
        n_chk++; if (bus.start_t_grad !== 1'b1) begin n_fail++; $display("FAIL gx_valid: got %b expected 1", bus.start_t_grad); end
        n_chk++; if (bus.gx !== 11'd1020) begin n_fail++; $display("FAIL gx_edge_gx: got %0d expected 1020", bus.gx); end
        n_chk++; if (bus.gy !== 11'd0) begin n_fail++; $display("FAIL gx_edge_gy: got %0d expected 0", bus.gy); end
        idle(1);
        n_chk++; if (bus.start_t_grad !== 1'b0) begin n_fail++; $display("FAIL gx_drain: got %b expected 0", bus.start_t_grad); end
        n_chk++; if (bus.gx !== 11'd0) begin n_fail++; $display("FAIL gx_zero_when_idle: got %0d expected 0", bus.gx); end
    endtask

    task automatic test_grad_y;
        bus.grad_ready = 1'b1;
        push(24'hFF0000, 1'b1);
        push(24'hFF0000, 1'b0);
        push(24'hFF0000, 1'b0);
        idle(1);
        n_chk++; if (bus.start_t_grad !== 1'b1) begin n_fail++; $display("FAIL gy_valid: got %b expected 1", bus.start_t_grad); end
        n_chk++; if (bus.gx !== 11'd0) begin n_fail++; $display("FAIL gy_edge_gx: got %0d expected 0", bus.gx); end
        n_chk++; if (bus.gy !== 11'd1020) begin n_fail++; $display("FAIL gy_edge_gy: got %0d expected 1020", bus.gy); end
        idle(1);
    endtask

    task automatic test_mixed;
        bus.grad_ready = 1'b1;
        push(24'h102030, 1'b1);
        push(24'h405060, 1'b0);
        push(24'h708090, 1'b0);
        idle(1);
        n_chk++; if (bus.gx !== 11'd384) begin n_fail++; $display("FAIL mixed_gx: got %0d expected 384", bus.gx); end
        n_chk++; if (bus.gy !== 11'd128) begin n_fail++; $display("FAIL mixed_gy: got %0d expected 128", bus.gy); end
        idle(1);
    endtask

    task automatic test_stall;
        int base;
        int exp_gx[3];
        exp_gx[0] = 1020;
        exp_gx[1] = 512;
        exp_gx[2] = 764;
        bus.grad_ready = 1'b0;
        q_gx.delete();
        q_gy.delete();
        base = n_out;
        push(24'h000000, 1'b1);
        push(24'h000000, 1'b0);
        push(24'hFFFFFF, 1'b0);
        push(24'h808080, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (bus.start_t_grad !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, bus.start_t_grad); end
            n_chk++; if (bus.gx !== 11'd1020) begin n_fail++; $display("FAIL stall_gx[%0d]: got %0d expected 1020", i, bus.gx); end
            n_chk++; if (bus.gy !== 11'd0) begin n_fail++; $display("FAIL stall_gy[%0d]: got %0d expected 0", i, bus.gy); end
            n_chk++; if (bus.col_ready !== 1'b0) begin n_fail++; $display("FAIL stall_col_ready[%0d]: got %b expected 0", i, bus.col_ready); end
            idle(1);
        end
        bus.grad_ready = 1'b1;
        push(24'h404040, 1'b0);
        idle(3);
        n_chk++; if (n_out - base != 3) begin n_fail++; $display("FAIL stall_count: got %0d expected 3", n_out - base); end
        if (q_gx.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_chk++; if (q_gx[i] != exp_gx[i] || q_gy[i] != 0) begin n_fail++; $display("FAIL stall_seq[%0d]: got gx=%0d gy=%0d expected %0d 0", i, q_gx[i], q_gy[i], exp_gx[i]); end
            end
        end
    endtask

    task automatic test_restart;
        int base;
        bus.grad_ready = 1'b1;
        base = n_out;
        push(24'hFFFFFF, 1'b1);
        for (int i = 1; i < 5; i++) push(24'hFFFFFF, 1'b0);
        idle(3);
        n_chk++; if (n_out - base != 3) begin n_fail++; $display("FAIL restart_old_count: got %0d expected 3", n_out - base); end
        base = n_out;
        q_gx.delete();
        q_gy.delete();
        push(24'h000000, 1'b1);
        push(24'h000000, 1'b0);
        idle(3);
        n_chk++; if (n_out - base != 0) begin n_fail++; $display("FAIL restart_cols01: got %0d expected 0", n_out - base); end
        for (int i = 2; i < W; i++) push(24'h000000, 1'b0);
        idle(3);
        n_chk++; if (n_out - base != W - 2) begin n_fail++; $display("FAIL restart_new_count: got %0d expected %0d", n_out - base, W - 2); end
        foreach (q_gx[i]) begin
            n_chk++; if (q_gx[i] != 0) begin n_fail++; $display("FAIL restart_value[%0d]: got gx=%0d expected 0", i, q_gx[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int base;
        bus.grad_ready = 1'b0;
        push(24'h000000, 1'b1);
        push(24'h000000, 1'b0);
        push(24'hFFFFFF, 1'b0);
        idle(1);
        n_chk++; if (bus.start_t_grad !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b expected 1", bus.start_t_grad); end
        n_rst = 1'b0;
        #1;
        n_chk++; if (bus.start_t_grad !== 1'b0) begin n_fail++; $display("FAIL rmid_start: got %b expected 0", bus.start_t_grad); end
        n_chk++; if (bus.gx !== 11'd0) begin n_fail++; $display("FAIL rmid_gx: got %0d expected 0", bus.gx); end
        n_chk++; if (bus.gy !== 11'd0) begin n_fail++; $display("FAIL rmid_gy: got %0d expected 0", bus.gy); end
        n_chk++; if (bus.col_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_col_ready: got %b expected 1", bus.col_ready); end
        @(negedge clk);
        #1;
        n_rst = 1'b1;
        bus.grad_ready = 1'b1;
        base = n_out;
        push(24'hFFFFFF, 1'b0);
        push(24'h000000, 1'b0);
        push(24'hFFFFFF, 1'b0);
        idle(3);
        n_chk++; if (n_out - base != 0) begin n_fail++; $display("FAIL rmid_ignored: got %0d expected 0", n_out - base); end
        push(24'h000000, 1'b1);
        push(24'h000000, 1'b0);
        push(24'hFFFFFF, 1'b0);
        idle(1);
        n_chk++; if (bus.start_t_grad !== 1'b1 || bus.gx !== 11'd1020) begin n_fail++; $display("FAIL rmid_recover: got valid=%b gx=%0d expected 1 1020", bus.start_t_grad, bus.gx); end
        idle(2);
    endtask

    initial begin
        n_rst          = 1'b0;
        bus.col_valid  = 1'b0;
        bus.col_in     = '0;
        bus.row_start  = 1'b0;
        bus.grad_ready = 1'b0;
        #1;
        test_reset();
        test_flat_row();
        test_grad_x();
        test_grad_y();
        test_mixed();
        test_stall();
        test_restart();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100000 ns, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
